// File: rtl/dds_par_loader.sv
// Parallel-port DDS programmer: optional master reset, table-driven
// register writes with a slowed strobe, then an I/O update pulse.
module dds_par_loader #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int DIV_W     = 16,
  parameter int RST_TICKS = 3,
  parameter int UPD_TICKS = 2,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  div,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_waddr,
  input  logic [ADDR_W-1:0] tbl_wa,
  input  logic [DATA_W-1:0] tbl_wd,
  input  logic [IDX_W:0]    tbl_len,
  input  logic              start,
  input  logic              do_mrst,
  output logic              mst_rst,
  output logic [ADDR_W-1:0] dds_a,
  output logic [DATA_W-1:0] dds_d,
  output logic              dds_wrb,
  output logic              io_ud,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TK_MAX = (RST_TICKS > UPD_TICKS) ? RST_TICKS : UPD_TICKS;
  localparam int TK_W   = $clog2(TK_MAX) + 1;
  localparam logic [TK_W-1:0] RST_LAST = TK_W'(RST_TICKS - 1);
  localparam logic [TK_W-1:0] UPD_LAST = TK_W'(UPD_TICKS - 1);
  localparam logic [IDX_W:0]  DEPTH_L  = (IDX_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_MRST, S_SETUP,
    S_STROBE, S_HOLD, S_UPDATE, S_DONE
  } state_t;

  state_t state, state_n;

  logic [IDX_W:0]  idx, idx_n;
  logic [TK_W-1:0] tk, tk_n;
  logic [IDX_W:0]  len_q;
  logic [DIV_W-1:0] div_q, cnt;
  logic            mrst_q;
  logic            tick, timed, accept;

  logic [ADDR_W+DATA_W-1:0] tbl [DEPTH];

  assign accept = (state == S_IDLE) && start && (tbl_len <= DEPTH_L);
  assign timed  = (state != S_IDLE) && (state != S_ARM) && (state != S_DONE);
  assign tick   = timed && (cnt == div_q);

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign mst_rst = (state == S_MRST);
  assign dds_wrb = (state != S_STROBE);
  assign io_ud   = (state == S_UPDATE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      tk    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      tk    <= tk_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tk_n    = tk;
    unique case (state)
      S_IDLE: if (accept) state_n = S_ARM;
      S_ARM: begin
        idx_n = '0;
        tk_n  = '0;
        if (mrst_q)            state_n = S_MRST;
        else if (len_q != '0)  state_n = S_SETUP;
        else                   state_n = S_UPDATE;
      end
      S_MRST: if (tick) begin
        if (tk == RST_LAST) begin
          tk_n    = '0;
          state_n = (len_q != '0) ? S_SETUP : S_UPDATE;
        end else begin
          tk_n = tk + 1'b1;
        end
      end
      S_SETUP:  if (tick) state_n = S_STROBE;
      S_STROBE: if (tick) state_n = S_HOLD;
      S_HOLD: if (tick) begin
        idx_n   = idx + 1'b1;
        state_n = (idx + 1'b1 < len_q) ? S_SETUP : S_UPDATE;
      end
      S_UPDATE: if (tick) begin
        if (tk == UPD_LAST) begin
          tk_n    = '0;
          state_n = S_DONE;
        end else begin
          tk_n = tk + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      div_q  <= '0;
      mrst_q <= 1'b0;
      cnt    <= '0;
      err    <= 1'b0;
      dds_a  <= '0;
      dds_d  <= '0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        len_q  <= tbl_len;
        div_q  <= div;
        mrst_q <= do_mrst;
      end
      err <= (state == S_IDLE) && start && (tbl_len > DEPTH_L);
      if (!timed || tick) cnt <= '0;
      else                cnt <= cnt + 1'b1;
      // bus is loaded on SETUP entry so a/d lead the strobe by a full tick
      if (state_n == S_SETUP && state != S_SETUP)
        {dds_a, dds_d} <= tbl[idx_n[IDX_W-1:0]];
      if (tbl_we && !busy)
        tbl[tbl_waddr] <= {tbl_wa, tbl_wd};
    end
  end

endmodule

// File: tb/tb_dds_par_loader.sv
// Bench for dds_par_loader: per-clk output timeline compared against
// a model built from tick counts of each sequence phase.
module tb_dds_par_loader;

  localparam int RST_T = 3;
  localparam int UPD_T = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] div = '0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_waddr = '0;
  logic [5:0]  tbl_wa = '0;
  logic [7:0]  tbl_wd = '0;
  logic [4:0]  tbl_len = '0;
  logic        start = 1'b0;
  logic        do_mrst = 1'b0;
  logic        mst_rst, dds_wrb, io_ud, busy, done, err;
  logic [5:0]  dds_a;
  logic [7:0]  dds_d;

  int checks = 0;
  int failures = 0;

  logic [5:0] m_a [DEPTH];
  logic [7:0] m_d [DEPTH];
  logic [5:0] pa = '0;
  logic [7:0] pd = '0;

  logic [19:0] vec;
  assign vec = {mst_rst, dds_a, dds_d, dds_wrb, io_ud, busy, done, err};

  dds_par_loader dut (
    .clk(clk), .rst_n(rst_n), .div(div),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
    .tbl_wa(tbl_wa), .tbl_wd(tbl_wd), .tbl_len(tbl_len),
    .start(start), .do_mrst(do_mrst),
    .mst_rst(mst_rst), .dds_a(dds_a), .dds_d(dds_d),
    .dds_wrb(dds_wrb), .io_ud(io_ud), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(
    input logic mr, input logic [5:0] a, input logic [7:0] d,
    input logic wrb, input logic ud, input logic bz,
    input logic dn, input logic er);
    return {mr, a, d, wrb, ud, bz, dn, er};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input int i, input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    tbl_we = 1'b1;
    tbl_waddr = 4'(i);
    tbl_wa = a;
    tbl_wd = d;
    @(negedge clk);
    tbl_we = 1'b0;
    m_a[i] = a;
    m_d[i] = d;
  endtask

  task automatic run_seq(input string tag, input int len, input int dv,
                         input bit mr, input bit inj);
    logic [19:0] q[$];
    int n;
    n = dv + 1;
    q.push_back(mk(0, pa, pd, 1, 0, 1, 0, 0));
    if (mr) repeat (RST_T * n) q.push_back(mk(1, pa, pd, 1, 0, 1, 0, 0));
    for (int i = 0; i < len; i++) begin
      repeat (n) q.push_back(mk(0, m_a[i], m_d[i], 1, 0, 1, 0, 0));
      repeat (n) q.push_back(mk(0, m_a[i], m_d[i], 0, 0, 1, 0, 0));
      repeat (n) q.push_back(mk(0, m_a[i], m_d[i], 1, 0, 1, 0, 0));
      pa = m_a[i];
      pd = m_d[i];
    end
    repeat (UPD_T * n) q.push_back(mk(0, pa, pd, 1, 1, 1, 0, 0));
    q.push_back(mk(0, pa, pd, 1, 0, 1, 1, 0));
    if (q.size() != (int'(mr) * RST_T + 3 * len + UPD_T) * n + 2)
      $display("model size unexpected %0d", q.size());
    @(negedge clk);
    div = 16'(dv);
    tbl_len = 5'(len);
    do_mrst = mr;
    start = 1'b1;
    @(posedge clk);
    foreach (q[k]) begin
      @(negedge clk);
      start = 1'b0;
      tbl_we = 1'b0;
      chk(tag, 32'(vec), 32'(q[k]));
      if (inj && k == 2) begin
        start = 1'b1;
        do_mrst = ~mr;
        div = 16'd9;
        tbl_we = 1'b1;
        tbl_waddr = 4'd0;
        tbl_wa = 6'h3f;
        tbl_wd = 8'hff;
      end
    end
    @(negedge clk);
    chk({tag, "_end"}, 32'(vec), 32'(mk(0, pa, pd, 1, 0, 0, 0, 0)));
  endtask

  initial begin
    logic [19:0] rst_v;
    int guard;
    rst_v = mk(0, 6'h0, 8'h0, 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      m_a[i] = '0;
      m_d[i] = '0;
    end
    #1 chk("reset", 32'(vec), 32'(rst_v));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset", 32'(vec), 32'(rst_v));

    wr(0, 6'h04, 8'h0C);
    wr(1, 6'h05, 8'hCC);
    run_seq("t1_mrst", 2, 0, 1, 0);
    run_seq("t2_div3", 1, 3, 0, 0);
    run_seq("t3_len0", 0, 0, 0, 0);

    @(negedge clk);
    tbl_len = 5'd17;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 32'(vec), 32'(mk(0, pa, pd, 1, 0, 0, 0, 1)));
    @(negedge clk);
    chk("err_clear", 32'(vec), 32'(mk(0, pa, pd, 1, 0, 0, 0, 0)));

    run_seq("t4_inj", 2, 1, 0, 1);
    run_seq("t4_tbl", 2, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      int nw;
      nw = int'($urandom_range(1, 6));
      for (int j = 0; j < nw; j++)
        wr(int'($urandom_range(0, DEPTH - 1)), 6'($urandom), 8'($urandom));
      run_seq("rand", int'($urandom_range(0, DEPTH)),
              int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    div = 16'd2;
    tbl_len = 5'd1;
    do_mrst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (dds_wrb && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("strobe_seen", 32'(guard < 200), 32'd1);
    rst_n = 1'b0;
    #1 chk("arst_mid", 32'(vec), 32'(rst_v));
    repeat (2) @(negedge clk);
    chk("arst_hold", 32'(vec), 32'(rst_v));
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      m_a[i] = '0;
      m_d[i] = '0;
    end
    pa = '0;
    pd = '0;
    run_seq("after_rst", DEPTH, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
